// File: rtl/stopwatch_btn_ctrl.sv
// stopwatch_btn_ctrl: debounced two-button front-end issuing start/stop/clear commands with ack wait and a lap FIFO.
// Define BTN_LONG_PRESS_EN to add a forced reset when btn_b is held for LONG_PRESS_CYCLES.
module stopwatch_btn_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter int          ACK_TIMEOUT     = 8,
   parameter int          LAP_DEPTH       = 4
`ifdef BTN_LONG_PRESS_EN
   ,
   parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100000000
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_btn_a,
   input  logic                       i_btn_b,
   input  logic [1:0]                 i_sw_status,
   input  logic [7:0]                 i_sw_minutes,
   input  logic [5:0]                 i_sw_seconds,
   output logic                       o_sw_start,
   output logic                       o_sw_stop,
   output logic                       o_sw_reset,
   output logic                       o_busy,
   output logic                       o_cmd_err,
   output logic [13:0]                o_lap_data,
   output logic                       o_lap_valid,
   input  logic                       i_lap_rd,
   output logic [$clog2(LAP_DEPTH):0] o_lap_count,
   output logic                       o_lap_overflow
);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic {READY, WAIT_ACK} state_t;
   state_t          r_state, w_state_nx;
   logic [1:0]      r_s1, r_s2, r_deb, r_deb_q, w_press;
   logic [15:0]     r_dcnt [2];
   logic [1:0]      r_exp, w_exp_nx;
   logic [CW-1:0]   r_ack_cnt, w_ack_nx;
   logic            r_err, w_err_nx, w_start_nx, w_stop_nx, w_reset_nx;
   logic            w_flush, w_lap, w_long, w_full, w_pop, w_push;
   logic [13:0]     r_mem [LAP_DEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [AW:0]     r_cnt;
   logic            r_ovf;
   // bit 0 is btn_a, bit 1 is btn_b throughout the input path
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_deb     <= '0;
         r_deb_q   <= '0;
         r_dcnt[0] <= '0;
         r_dcnt[1] <= '0;
      end else begin
         r_s1    <= {i_btn_b, i_btn_a};
         r_s2    <= r_s1;
         r_deb_q <= r_deb;
         for (int i = 0; i < 2; i++)
            if (r_s2[i] == r_deb[i]) r_dcnt[i] <= '0;
            else if (r_dcnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
               r_deb[i]  <= r_s2[i];
               r_dcnt[i] <= '0;
            end else r_dcnt[i] <= r_dcnt[i] + 16'd1;
      end
   end
   assign w_press = r_deb & ~r_deb_q;
`ifdef BTN_LONG_PRESS_EN
   logic [31:0] r_hold;
   // saturates one past the trigger so a single hold fires only once
   always_ff @(posedge clk) begin
      if (rst || !r_deb[1]) r_hold <= '0;
      else if (r_hold != LONG_PRESS_CYCLES) r_hold <= r_hold + 32'd1;
   end
   assign w_long = r_deb[1] && r_hold == LONG_PRESS_CYCLES - 32'd1;
`else
   assign w_long = 1'b0;
`endif
   assign w_lap = w_press[1] && i_sw_status == 2'b01;
   always_comb begin
      w_state_nx = r_state;
      w_exp_nx   = r_exp;
      w_ack_nx   = r_ack_cnt;
      w_err_nx   = r_err;
      w_start_nx = 1'b0;
      w_stop_nx  = 1'b0;
      w_reset_nx = 1'b0;
      w_flush    = 1'b0;
      if (r_state == READY) begin
         if (w_press[0] && i_sw_status != 2'b11) begin
            w_start_nx = i_sw_status != 2'b01;
            w_stop_nx  = i_sw_status == 2'b01;
            w_exp_nx   = (i_sw_status == 2'b01) ? 2'b10 : 2'b01;
            w_state_nx = WAIT_ACK;
            w_ack_nx   = '0;
         end else if (w_press[1] && i_sw_status == 2'b10) begin
            w_reset_nx = 1'b1;
            w_flush    = 1'b1;
            w_exp_nx   = 2'b00;
            w_state_nx = WAIT_ACK;
            w_ack_nx   = '0;
         end
      end else if (i_sw_status == r_exp) w_state_nx = READY;
      else if (r_ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
         w_err_nx   = 1'b1;
         w_state_nx = READY;
      end else w_ack_nx = r_ack_cnt + CW'(1);
      if (w_long) begin
         w_start_nx = 1'b0;
         w_stop_nx  = 1'b0;
         w_reset_nx = 1'b1;
         w_flush    = 1'b1;
         w_exp_nx   = 2'b00;
         w_state_nx = WAIT_ACK;
         w_ack_nx   = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= READY;
         r_exp      <= '0;
         r_ack_cnt  <= '0;
         r_err      <= 1'b0;
         o_sw_start <= 1'b0;
         o_sw_stop  <= 1'b0;
         o_sw_reset <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_exp      <= w_exp_nx;
         r_ack_cnt  <= w_ack_nx;
         r_err      <= w_err_nx;
         o_sw_start <= w_start_nx;
         o_sw_stop  <= w_stop_nx;
         o_sw_reset <= w_reset_nx;
      end
   end
   // a pop in the same cycle frees the slot a full FIFO needs for the push
   assign w_full = r_cnt == (AW+1)'(LAP_DEPTH);
   assign w_pop  = i_lap_rd && r_cnt != '0;
   assign w_push = w_lap && (!w_full || w_pop) && !w_flush;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {i_sw_minutes, i_sw_seconds};
   end
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_lap && !w_push) r_ovf <= 1'b1;
      end
   end
   assign o_busy         = r_state == WAIT_ACK;
   assign o_cmd_err      = r_err;
   assign o_lap_valid    = r_cnt != '0;
   assign o_lap_count    = r_cnt;
   assign o_lap_overflow = r_ovf;
   assign o_lap_data     = o_lap_valid ? r_mem[r_rp] : '0;
endmodule

// File: doc/stopwatch_btn_ctrl.md
Name: stopwatch_btn_ctrl

Overview:
Front-end controller that sequences the stopwatch datapath from two raw push-buttons. It synchronises and debounces the buttons and decodes presses against the live stopwatch status. It issues single-cycle start/stop/reset commands and waits for the status to acknowledge each one. It also captures lap times into a small FIFO for downstream readout.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronised samples required to accept a new button level
ACK_TIMEOUT, 8, max cycles to wait for sw_status to reflect an issued command
LAP_DEPTH, 4, lap FIFO entries; power of 2, >= 2
LONG_PRESS_CYCLES, 32'd100000000, btn_b hold time for forced reset (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_a  in  1  raw async button: start/stop toggle
btn_b  in  1  raw async button: lap / clear
sw_status  in  2  stopwatch status: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid
sw_minutes  in  8  stopwatch minutes
sw_seconds  in  6  stopwatch seconds
sw_start  out  1  one-cycle start command
sw_stop  out  1  one-cycle stop command
sw_reset  out  1  one-cycle clear command
busy  out  1  high while waiting for a command acknowledge
cmd_err  out  1  sticky: acknowledge timeout seen
lap_data  out  14  FIFO head, {minutes, seconds}
lap_valid  out  1  FIFO not empty
lap_rd  in  1  pop head; ignored when lap_valid=0
lap_count  out  clog2(LAP_DEPTH)+1  FIFO occupancy
lap_overflow  out  1  sticky: lap dropped because FIFO full

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs 0.
  - FSM to READY; FIFO empty.
  - Synchroniser and debounced levels 0; debounce counters 0.
- Button input path:
  - Each button passes through a 2-FF synchroniser, then a debouncer.
  - Debounced level flips only after the synchronised sample differs from it for DEBOUNCE_CYCLES consecutive cycles. Any matching sample clears the counter.
  - A press event is a 0->1 transition of the debounced level, valid for one cycle. Release is ignored.
- FSM states: READY, WAIT_ACK.
  - READY, press_a event:
    - status IDLE or PAUSED: sw_start=1 next cycle; expected status = 01.
    - status RUNNING: sw_stop=1 next cycle; expected status = 10.
    - status 11: event dropped.
  - READY, press_b event:
    - status RUNNING: lap capture (below).
    - status PAUSED: sw_reset=1 next cycle, FIFO flushed the same cycle, expected status = 00.
    - status IDLE or 11: dropped.
  - Issuing any command moves the FSM to WAIT_ACK and asserts busy.
  - WAIT_ACK:
    - Count cycles from the command pulse.
    - sw_status equal to expected -> READY.
    - Count reaches ACK_TIMEOUT -> set cmd_err, then READY.
    - Command-generating presses in this state are dropped. Lap captures are still accepted.
- Command pulses: exactly one cycle wide; at most one of sw_start/sw_stop/sw_reset high in any cycle.
- Simultaneous press_a and press_b in READY:
  - press_a command is issued.
  - press_b lap capture still occurs if status is RUNNING.
  - press_b reset is dropped.
- Lap capture:
  - Pushes {sw_minutes, sw_seconds} sampled in the event cycle.
  - Becomes visible on lap_data/lap_valid one cycle later.
  - FIFO full with no pop that cycle: push dropped, lap_overflow set.
  - FIFO full with a pop in the same cycle: push accepted, no overflow.
- FIFO read: first-word fall-through; lap_rd with lap_valid pops the head at the clk edge.
- Flush: empties the FIFO and clears lap_overflow. It does not clear cmd_err; only rst clears cmd_err.

Optional Feature:
Macro BTN_LONG_PRESS_EN.
- Defined: btn_b debounced high for LONG_PRESS_CYCLES consecutive cycles, in any status and any FSM state, forces:
  - sw_reset pulse;
  - FIFO flush;
  - FSM to WAIT_ACK with expected status 00.
  Fires once per hold. The initial press still takes its normal action.
- Undefined: no hold counter; btn_b acts only on press events.

Test Plan:
- Params DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, LAP_DEPTH=4, sw_status=00; btn_a high for 3 cycles then low -> no command. btn_a held high for 10 cycles -> exactly one sw_start pulse.
- sw_status=00, press btn_a, model drives status 01 two cycles after sw_start -> busy high for 2 cycles then low, cmd_err=0. Press btn_a again -> sw_stop pulse.
- After an issued start, hold sw_status=00 -> busy drops 8 cycles after the pulse, cmd_err=1 and stays 1 until rst.
- RUNNING: times 0:05, 0:12, 1:03, 2:00, 2:30 on successive btn_b presses with no reads -> lap_count=4, lap_overflow=1. Reads return 0x005, 0x00C, 0x043, 0x080 in order.
- PAUSED with 3 laps queued, press btn_b -> sw_reset pulse, lap_count=0, lap_valid=0, lap_overflow=0.
- Assert rst while in WAIT_ACK with 2 laps queued -> next cycle busy=0, lap_count=0, and all command outputs 0.
